eth_mdio_resp: RTL

MDIO management responder (PHY-side Clause 22 slave) that answers frames issued by the eth_mdio initiator. It emulates a small PHY register file for simulation and loopback benches, and for FPGA-to-FPGA bring-up where the second board stands in for the PHY. It oversamples MDC on a single fast clock, decodes read and write frames, drives turnaround and read data, and reports register writes to the surrounding logic.

---
 rtl/eth_mdio_resp_if.sv | 24 ++
 rtl/eth_mdio_resp.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mdio_resp_if.sv
// MDIO responder pin and register-write report bundle.
// slave: the responder side; master: the initiator/bench side.
`timescale 1ns/1ps
interface eth_mdio_resp_if;
   logic        MDC;
   logic        MDIO_I;
   logic        MDIO_O;
   logic        MDIO_Oe;
   logic        Reg_Wr_Strb;
   logic [4:0]  Reg_Wr_Addr;
   logic [15:0] Reg_Wr_Data;
   logic        Soft_Rst;
   logic        Frame_Err;

   modport slave (
      input  MDC, MDIO_I,
      output MDIO_O, MDIO_Oe, Reg_Wr_Strb, Reg_Wr_Addr, Reg_Wr_Data, Soft_Rst, Frame_Err
   );

   modport master (
      output MDC, MDIO_I,
      input  MDIO_O, MDIO_Oe, Reg_Wr_Strb, Reg_Wr_Addr, Reg_Wr_Data, Soft_Rst, Frame_Err
   );
endinterface

// File: rtl/eth_mdio_resp.sv
// Clause 22 MDIO responder emulating a small PHY register file.
// MDC is oversampled on Clk; every protocol step happens on a detected MDC rise.
// Optional build macro MDIO_PREAMBLE_SUPPRESS_EN: accept a start after a single
// preamble 1 instead of 32.
`timescale 1ns/1ps
module eth_mdio_resp #(
   parameter logic [4:0]  pPhy_Addr = 5'h01,
   parameter logic [15:0] pPhy_Id1  = 16'h0007,
   parameter logic [15:0] pPhy_Id2  = 16'hC0F1
) (
   input logic           Clk,
   input logic           Rstn,
   eth_mdio_resp_if.slave bus
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   localparam logic [5:0] PreNeed = 6'd1;
`else
   localparam logic [5:0] PreNeed = 6'd32;
`endif

   typedef enum logic [3:0] {
      StPre, StSt, StOp, StPhy, StReg, StTa, StRd, StWr, StSkip
   } state_e;

   function automatic logic [15:0] rst_val(input int idx);
      case (idx)
         0:       rst_val = 16'h3100;
         4:       rst_val = 16'h01E1;
         default: rst_val = 16'h0000;
      endcase
   endfunction

   state_e      state_q, state_d;
   logic [5:0]  pre_cnt_q, pre_cnt_d;
   logic [5:0]  bit_q, bit_d;
   logic [1:0]  op_q, op_d;
   logic [4:0]  phy_q, phy_d;
   logic [4:0]  reg_q, reg_d;
   logic        match_q, match_d;
   logic [15:0] shift_q, shift_d;
   logic        mdo_q, mdo_d;
   logic        oe_q, oe_d;
   logic        strb_q, strb_d;
   logic [4:0]  wa_q, wa_d;
   logic [15:0] wd_q, wd_d;
   logic        srst_q, srst_d;
   logic        err_q, err_d;
   logic [15:0] mem_q [16];
   logic [15:0] mem_d [16];

   logic        mdc_s1, mdc_s2, mdc_s3;
   logic        mdio_s1, mdio_s2;
   logic        rise;
   logic [5:0]  cur;
   logic [4:0]  reg_full;
   logic [15:0] wr_data;
   logic [15:0] rd_val;

   assign rise     = mdc_s2 & ~mdc_s3;
   // Number of the frame bit being sampled at this rise.
   assign cur      = bit_q + 6'd1;
   assign reg_full = {reg_q[3:0], mdio_s2};
   assign wr_data  = {shift_q[14:0], mdio_s2};

   assign bus.MDIO_O      = mdo_q;
   assign bus.MDIO_Oe     = oe_q;
   assign bus.Reg_Wr_Strb = strb_q;
   assign bus.Reg_Wr_Addr = wa_q;
   assign bus.Reg_Wr_Data = wd_q;
   assign bus.Soft_Rst    = srst_q;
   assign bus.Frame_Err   = err_q;

   // Two-flop synchronizers for MDC and MDIO, plus MDC history for edge detect.
   always_ff @(posedge Clk or negedge Rstn) begin
      if (!Rstn) begin
         mdc_s1  <= 1'b0;
         mdc_s2  <= 1'b0;
         mdc_s3  <= 1'b0;
         mdio_s1 <= 1'b1;
         mdio_s2 <= 1'b1;
      end else begin
         mdc_s1  <= bus.MDC;
         mdc_s2  <= mdc_s1;
         mdc_s3  <= mdc_s2;
         mdio_s1 <= bus.MDIO_I;
         mdio_s2 <= mdio_s1;
      end
   end

   // Register read mux; bit 15 of BMCR is self-clearing so it always reads 0.
   always_comb begin
      rd_val = 16'h0000;
      if (reg_full == 5'd1)      rd_val = 16'h7809;
      else if (reg_full == 5'd2) rd_val = pPhy_Id1;
      else if (reg_full == 5'd3) rd_val = pPhy_Id2;
      else if (!reg_full[4])     rd_val = mem_q[reg_full[3:0]] & 16'h7FFF;
   end

   // Frame decoder: next state, pad drive and write commit.
   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      bit_d     = bit_q;
      op_d      = op_q;
      phy_d     = phy_q;
      reg_d     = reg_q;
      match_d   = match_q;
      shift_d   = shift_q;
      mdo_d     = mdo_q;
      oe_d      = oe_q;
      strb_d    = 1'b0;
      wa_d      = wa_q;
      wd_d      = wd_q;
      srst_d    = 1'b0;
      err_d     = 1'b0;
      mem_d     = mem_q;
      if (rise) begin
         if (state_q != StPre) bit_d = cur;
         unique case (state_q)
            StPre: begin
               if (mdio_s2) begin
                  if (pre_cnt_q < PreNeed) pre_cnt_d = pre_cnt_q + 6'd1;
               end else if (pre_cnt_q == PreNeed) begin
                  state_d   = StSt;
                  bit_d     = 6'd1;
                  pre_cnt_d = 6'd0;
               end else begin
                  pre_cnt_d = 6'd0;
               end
            end
            StSt: begin
               if (mdio_s2) begin
                  state_d = StOp;
               end else begin
                  err_d     = 1'b1;
                  state_d   = StPre;
                  pre_cnt_d = 6'd0;
               end
            end
            StOp: begin
               op_d = {op_q[0], mdio_s2};
               if (cur == 6'd4) begin
                  if ({op_q[0], mdio_s2} == 2'b10 || {op_q[0], mdio_s2} == 2'b01) begin
                     state_d = StPhy;
                  end else begin
                     err_d   = 1'b1;
                     state_d = StSkip;
                  end
               end
            end
            StPhy: begin
               phy_d = {phy_q[3:0], mdio_s2};
               if (cur == 6'd9) begin
                  match_d = ({phy_q[3:0], mdio_s2} == pPhy_Addr);
                  state_d = StReg;
               end
            end
            StReg: begin
               reg_d = reg_full;
               if (cur == 6'd14) begin
                  // Snapshot read data now so a later write cannot disturb it.
                  shift_d = rd_val;
                  state_d = match_q ? StTa : StSkip;
               end
            end
            StTa: begin
               if (cur == 6'd15) begin
                  if (op_q == 2'b10) begin
                     oe_d  = 1'b1;
                     mdo_d = 1'b0;
                  end
               end else begin
                  if (op_q == 2'b10) begin
                     mdo_d   = shift_q[15];
                     shift_d = {shift_q[14:0], 1'b0};
                     state_d = StRd;
                  end else begin
                     state_d = StWr;
                  end
               end
            end
            StRd: begin
               if (cur == 6'd32) begin
                  oe_d      = 1'b0;
                  mdo_d     = 1'b0;
                  state_d   = StPre;
                  pre_cnt_d = 6'd0;
               end else begin
                  mdo_d   = shift_q[15];
                  shift_d = {shift_q[14:0], 1'b0};
               end
            end
            StWr: begin
               shift_d = wr_data;
               if (cur == 6'd32) begin
                  strb_d    = 1'b1;
                  wa_d      = reg_q;
                  wd_d      = wr_data;
                  state_d   = StPre;
                  pre_cnt_d = 6'd0;
                  if (reg_q == 5'd0 && wr_data[15]) begin
                     srst_d = 1'b1;
                     for (int i = 0; i < 16; i++) mem_d[i] = rst_val(i);
                  end else if (reg_q == 5'd0 || (!reg_q[4] && reg_q[3:0] >= 4'd4)) begin
                     mem_d[reg_q[3:0]] = wr_data;
                  end
               end
            end
            StSkip: begin
               if (cur == 6'd32) begin
                  state_d   = StPre;
                  pre_cnt_d = 6'd0;
               end
            end
            default: begin
               state_d   = StPre;
               pre_cnt_d = 6'd0;
            end
         endcase
      end
   end

   // State, output and storage registers.
   always_ff @(posedge Clk or negedge Rstn) begin
      if (!Rstn) begin
         state_q   <= StPre;
         pre_cnt_q <= 6'd0;
         bit_q     <= 6'd0;
         op_q      <= 2'b00;
         phy_q     <= 5'd0;
         reg_q     <= 5'd0;
         match_q   <= 1'b0;
         shift_q   <= 16'h0000;
         mdo_q     <= 1'b0;
         oe_q      <= 1'b0;
         strb_q    <= 1'b0;
         wa_q      <= 5'd0;
         wd_q      <= 16'h0000;
         srst_q    <= 1'b0;
         err_q     <= 1'b0;
         for (int i = 0; i < 16; i++) mem_q[i] <= rst_val(i);
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
         bit_q     <= bit_d;
         op_q      <= op_d;
         phy_q     <= phy_d;
         reg_q     <= reg_d;
         match_q   <= match_d;
         shift_q   <= shift_d;
         mdo_q     <= mdo_d;
         oe_q      <= oe_d;
         strb_q    <= strb_d;
         wa_q      <= wa_d;
         wd_q      <= wd_d;
         srst_q    <= srst_d;
         err_q     <= err_d;
         mem_q     <= mem_d;
      end
   end

endmodule
